// File: rtl/riscv_pkg.sv
// Shared types and encodings for the 3-stage RV32I control path.
// Opcodes, ALU/PC/writeback/forward encodings and the stage register bundle.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [3:0] UART_NIBBLE = 4'h8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } aluop_e;

  typedef enum logic [1:0] {
    PC_HOLD, PC_PLUS4, PC_TARGET, PC_RESET
  } pcsel_e;

  typedef enum logic [1:0] {
    WB_PC4, WB_ALU, WB_DMEM, WB_UART
  } wbsrc_e;

  typedef enum logic [1:0] {
    FWD_RF, FWD_X, FWD_M
  } fwd_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwr;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    wbsrc_e     wbsrc;
  } stage_t;

  typedef struct packed {
    stage_t     st;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    aluop_e     aluop;
  } ctrl_t;

  function automatic aluop_e alu_of(
    input logic [2:0] f3,
    input logic       b30,
    input logic       is_r
  );
    aluop_e op;
    case (f3)
      3'b000:  op = (is_r & b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // X is younger than M, so its result wins when both target rs.
  function automatic fwd_e fwd_sel(
    input stage_t     x,
    input stage_t     m,
    input logic [4:0] rs
  );
    fwd_e f;
    f = FWD_RF;
    if (rs != 5'd0) begin
      if (x.valid & x.regwr & (x.rd == rs))
        f = FWD_X;
      else if (m.valid & m.regwr & (m.rd == rs))
        f = FWD_M;
    end
    return f;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Pure combinational RV32I decode of the instruction in D.
// Produces the stage bundle plus source-register usage and ALU op.
module control_decoder
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] inst_i,
  output ctrl_t           ctrl_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic       b30;
  logic       unused_bits;

  assign op  = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign b30 = inst_i[30];
  assign unused_bits = ^{inst_i[31], inst_i[29:25]};

  always_comb begin
    ctrl_o          = '0;
    ctrl_o.st.rd    = inst_i[11:7];
    ctrl_o.rs1      = inst_i[19:15];
    ctrl_o.rs2      = inst_i[24:20];
    ctrl_o.st.wbsrc = WB_ALU;
    ctrl_o.aluop    = ALU_ADD;
    unique case (1'b1)
      op == OP_R: begin
        ctrl_o.st.valid = 1'b1;
        ctrl_o.st.regwr = 1'b1;
        ctrl_o.use_rs1  = 1'b1;
        ctrl_o.use_rs2  = 1'b1;
        ctrl_o.aluop    = alu_of(f3, b30, 1'b1);
      end
      op == OP_I: begin
        ctrl_o.st.valid = 1'b1;
        ctrl_o.st.regwr = 1'b1;
        ctrl_o.use_rs1  = 1'b1;
        ctrl_o.aluop    = alu_of(f3, b30, 1'b0);
      end
      op == OP_LOAD: begin
        ctrl_o.st.valid   = 1'b1;
        ctrl_o.st.regwr   = 1'b1;
        ctrl_o.st.is_load = 1'b1;
        ctrl_o.st.wbsrc   = WB_DMEM;
        ctrl_o.use_rs1    = 1'b1;
      end
      op == OP_STORE: begin
        ctrl_o.st.valid    = 1'b1;
        ctrl_o.st.is_store = 1'b1;
        ctrl_o.use_rs1     = 1'b1;
        ctrl_o.use_rs2     = 1'b1;
      end
      op == OP_BRANCH: begin
        ctrl_o.st.valid     = 1'b1;
        ctrl_o.st.is_branch = 1'b1;
        ctrl_o.use_rs1      = 1'b1;
        ctrl_o.use_rs2      = 1'b1;
        ctrl_o.aluop        = ALU_SUB;
      end
      (op == OP_JAL) || (op == OP_JALR): begin
        ctrl_o.st.valid   = 1'b1;
        ctrl_o.st.regwr   = 1'b1;
        ctrl_o.st.is_jump = 1'b1;
        ctrl_o.st.wbsrc   = WB_PC4;
        ctrl_o.use_rs1    = (op == OP_JALR);
      end
      (op == OP_LUI) || (op == OP_AUIPC): begin
        ctrl_o.st.valid = 1'b1;
        ctrl_o.st.regwr = 1'b1;
      end
      default: ;
    endcase
    if (ctrl_o.st.rd == 5'd0)
      ctrl_o.st.regwr = 1'b0;
  end

endmodule

// File: rtl/pipeline_control.sv
// Hazard, forwarding and stage-register control for the D/X/M pipeline.
// Drives PC select, operand forwards, ALU op and M-stage writeback controls.
module pipeline_control
  import riscv_pkg::*;
#(
  parameter logic [3:0] UART_NIB = UART_NIBBLE
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [XLEN-1:0] inst_doutb,
  input  logic            branch_taken,
  input  logic [3:0]      load_addr_hi,
  output logic [1:0]      PC_sel,
  output logic [1:0]      data_forward_ALU1,
  output logic [1:0]      data_forward_ALU2,
  output logic [3:0]      ALUop,
  output logic            RegWr,
  output logic [1:0]      wbsrc,
  output logic            dmem_we
);

  ctrl_t  d;
  stage_t x_q, x_d;
  stage_t m_q, m_d;
  logic   rst_q;
  logic   redirect;
  logic   stall;
  logic   hit1, hit2;
  logic   unused_m;

  control_decoder u_dec (
    .inst_i (inst_doutb),
    .ctrl_o (d)
  );

  assign redirect = x_q.valid
                  & (x_q.is_jump
                  | (x_q.is_branch & branch_taken));

  assign hit1  = d.use_rs1 & (d.rs1 == x_q.rd);
  assign hit2  = d.use_rs2 & (d.rs2 == x_q.rd);
  assign stall = x_q.valid & x_q.is_load
               & x_q.regwr & (hit1 | hit2);

  assign unused_m = ^{m_q.is_load, m_q.is_branch,
                      m_q.is_jump};

  // D is discarded on the cycle the PC reloads the reset vector.
  always_comb begin
    m_d = x_q;
    if (x_q.is_load)
      m_d.wbsrc = (load_addr_hi == UART_NIB)
                ? WB_UART : WB_DMEM;
    x_d = d.st;
    if (rst_q | redirect | stall)
      x_d.valid = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      x_q   <= '0;
      m_q   <= '0;
      rst_q <= 1'b1;
    end else begin
      x_q   <= x_d;
      m_q   <= m_d;
      rst_q <= 1'b0;
    end
  end

  always_comb begin
    if (Reset | rst_q)
      PC_sel = PC_RESET;
    else if (redirect)
      PC_sel = PC_TARGET;
    else if (stall)
      PC_sel = PC_HOLD;
    else
      PC_sel = PC_PLUS4;
  end

  always_comb begin
    data_forward_ALU1 = FWD_RF;
    data_forward_ALU2 = FWD_RF;
    RegWr             = 1'b0;
    dmem_we           = 1'b0;
    wbsrc             = WB_PC4;
    if (!Reset) begin
      data_forward_ALU1 = fwd_sel(x_q, m_q, d.rs1);
      data_forward_ALU2 = fwd_sel(x_q, m_q, d.rs2);
      RegWr             = m_q.valid & m_q.regwr;
      dmem_we           = m_q.valid & m_q.is_store;
      if (m_q.valid)
        wbsrc = m_q.wbsrc;
    end
  end

  assign ALUop = d.aluop;

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized and directed checks of pipeline_control against an
// instruction-level model of the D/X/M pipeline.
module tb_pipeline_control;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] inst_doutb = NOP;
  logic        branch_taken = 1'b0;
  logic [3:0]  load_addr_hi = 4'h0;
  logic [1:0]  PC_sel;
  logic [1:0]  data_forward_ALU1;
  logic [1:0]  data_forward_ALU2;
  logic [3:0]  ALUop;
  logic        RegWr;
  logic [1:0]  wbsrc;
  logic        dmem_we;

  pipeline_control dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .inst_doutb        (inst_doutb),
    .branch_taken      (branch_taken),
    .load_addr_hi      (load_addr_hi),
    .PC_sel            (PC_sel),
    .data_forward_ALU1 (data_forward_ALU1),
    .data_forward_ALU2 (data_forward_ALU2),
    .ALUop             (ALUop),
    .RegWr             (RegWr),
    .wbsrc             (wbsrc),
    .dmem_we           (dmem_we)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  // Model: raw instruction words occupying X and M.
  logic        mx_v = 1'b0;
  logic        mm_v = 1'b0;
  logic        post = 1'b0;
  logic [31:0] mx_i = NOP;
  logic [31:0] mm_i = NOP;
  logic [3:0]  mm_hi = 4'h0;

  logic [1:0]  s_pc, s_f1, s_f2, s_wb;
  logic        s_rw, s_we;
  logic [3:0]  s_alu;

  function automatic logic [6:0] opc(input logic [31:0] i);
    return i[6:0];
  endfunction

  function automatic logic [4:0] rdf(input logic [31:0] i);
    return i[11:7];
  endfunction

  function automatic bit known(input logic [31:0] i);
    case (opc(i))
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writes(input logic [31:0] i);
    case (opc(i))
      OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC: return rdf(i) != 5'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_jmp(input logic [31:0] i);
    return opc(i) == OP_JAL || opc(i) == OP_JALR;
  endfunction

  function automatic bit reads(
    input logic [31:0] i,
    input logic [4:0]  r
  );
    case (opc(i))
      OP_R, OP_STORE, OP_BRANCH:
        return i[19:15] == r || i[24:20] == r;
      OP_I, OP_LOAD, OP_JALR:
        return i[19:15] == r;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] wb_exp(
    input logic [31:0] i,
    input logic [3:0]  hi
  );
    if (opc(i) == OP_LOAD) return (hi == 4'h8) ? 2'd3 : 2'd2;
    if (is_jmp(i)) return 2'd0;
    return 2'd1;
  endfunction

  function automatic logic [3:0] alu_exp(input logic [31:0] i);
    logic [2:0] f = i[14:12];
    if (opc(i) == OP_BRANCH) return 4'd1;
    if (opc(i) != OP_R && opc(i) != OP_I) return 4'd0;
    case (f)
      3'd0: return (opc(i) == OP_R && i[30]) ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return i[30] ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (rs == 5'd0) return 2'd0;
    if (mx_v && writes(mx_i) && rdf(mx_i) == rs) return 2'd1;
    if (mm_v && writes(mm_i) && rdf(mm_i) == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i = $urandom;
    int k = $urandom_range(0, 11);
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    case (k)
      0, 1: i[6:0] = OP_R;
      2:  i[6:0] = OP_I;
      3, 4: i[6:0] = OP_LOAD;
      5:  i[6:0] = OP_STORE;
      6:  i[6:0] = OP_BRANCH;
      7:  i[6:0] = OP_JAL;
      8:  i[6:0] = OP_JALR;
      9:  i[6:0] = OP_LUI;
      10: i[6:0] = OP_AUIPC;
      default: i[6:0] = 7'b1110011;
    endcase
    return i;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cycle(
    input logic        rst,
    input logic [31:0] ins,
    input logic        bt,
    input logic [3:0]  hi
  );
    logic [1:0] e_pc;
    bit redir, stl;
    Reset = rst;
    inst_doutb = ins;
    branch_taken = bt;
    load_addr_hi = hi;
    @(negedge Clock);
    redir = mx_v && (is_jmp(mx_i)
          || (opc(mx_i) == OP_BRANCH && bt));
    stl = mx_v && opc(mx_i) == OP_LOAD && writes(mx_i)
        && reads(ins, rdf(mx_i));
    if (rst || post) e_pc = 2'd3;
    else if (redir) e_pc = 2'd2;
    else if (stl)   e_pc = 2'd0;
    else            e_pc = 2'd1;
    chk("pc_sel", PC_sel, e_pc);
    chk("fwd1", data_forward_ALU1, rst ? 2'd0 : fwd_exp(ins[19:15]));
    chk("fwd2", data_forward_ALU2, rst ? 2'd0 : fwd_exp(ins[24:20]));
    chk("aluop", ALUop, alu_exp(ins));
    chk("regwr", RegWr, !rst && mm_v && writes(mm_i));
    chk("dmem_we", dmem_we,
        !rst && mm_v && opc(mm_i) == OP_STORE);
    chk("wbsrc", wbsrc,
        (!rst && mm_v) ? wb_exp(mm_i, mm_hi) : 2'd0);
    s_pc = PC_sel; s_f1 = data_forward_ALU1;
    s_f2 = data_forward_ALU2; s_wb = wbsrc;
    s_rw = RegWr; s_we = dmem_we; s_alu = ALUop;
    @(posedge Clock);
    if (rst) begin
      mx_v = 1'b0; mm_v = 1'b0; post = 1'b1;
    end else begin
      mm_v = mx_v; mm_i = mx_i; mm_hi = hi;
      mx_v = known(ins) && e_pc == 2'd1;
      mx_i = ins;
      post = 1'b0;
    end
    #1;
  endtask

  task automatic run(input logic [31:0] ins);
    cycle(1'b0, ins, 1'b0, 4'h0);
  endtask

  logic [31:0] cur;

  initial begin
    for (int n = 0; n < 3; n++) begin
      cycle(1'b1, NOP, 1'b0, 4'h0);
      chk("lit_rst_pc", s_pc, 2'd3);
      chk("lit_rst_rw", s_rw, 1'b0);
      chk("lit_rst_we", s_we, 1'b0);
    end
    run(NOP);
    chk("lit_post_rst_pc", s_pc, 2'd3);

    // addi x1,x0,5 ; add x2,x1,x1
    run(32'h0050_0093);
    run(32'h0010_8133);
    chk("lit_fwd1_x", s_f1, 2'd1);
    chk("lit_fwd2_x", s_f2, 2'd1);
    run(NOP);
    chk("lit_addi_rw", s_rw, 1'b1);
    chk("lit_addi_wb", s_wb, 2'd1);
    run(NOP); run(NOP);

    // addi x1,x0,7 ; nop ; sub x3,x1,x0
    run(32'h0070_0093);
    run(NOP);
    run(32'h4000_81B3);
    chk("lit_fwd1_m", s_f1, 2'd2);
    chk("lit_sub_alu", s_alu, 4'd1);
    // addi x0,x0,7 ; nop ; sub x3,x0,x0
    run(32'h0070_0013);
    run(NOP);
    run(32'h4000_01B3);
    chk("lit_x0_fwd1", s_f1, 2'd0);
    chk("lit_x0_rw", s_rw, 1'b0);
    run(NOP); run(NOP);

    // lw x5,0(x6) from UART space ; add x7,x5,x0
    run(32'h0003_2283);
    cycle(1'b0, 32'h0002_83B3, 1'b0, 4'h8);
    chk("lit_lu_stall", s_pc, 2'd0);
    run(32'h0002_83B3);
    chk("lit_lu_pc", s_pc, 2'd1);
    chk("lit_lu_fwd", s_f1, 2'd2);
    chk("lit_lu_wb", s_wb, 2'd3);
    run(NOP); run(NOP);

    // beq x1,x2 taken
    run(32'h0020_8063);
    cycle(1'b0, 32'h0010_0213, 1'b1, 4'h0);
    chk("lit_br_pc", s_pc, 2'd2);
    run(NOP);
    run(NOP);
    chk("lit_br_bubble", s_rw, 1'b0);

    // jal x1,+8
    run(32'h0080_00EF);
    run(32'h0010_0213);
    chk("lit_jal_pc", s_pc, 2'd2);
    run(NOP);
    chk("lit_jal_rw", s_rw, 1'b1);
    chk("lit_jal_wb", s_wb, 2'd0);
    run(NOP);
    chk("lit_jal_sq", s_rw, 1'b0);

    // reset with writers in flight
    run(32'h0010_0093);
    run(32'h0010_0113);
    run(32'h0010_0193);
    cycle(1'b1, NOP, 1'b0, 4'h0);
    chk("lit_mid_rst_rw", s_rw, 1'b0);
    for (int n = 0; n < 3; n++) begin
      run(32'h0010_0093);
      chk("lit_after_rst_rw", s_rw, 1'b0);
    end

    cur = NOP;
    for (int n = 0; n < 4000; n++) begin
      if (s_pc != 2'd0) cur = rand_inst();
      cycle($urandom_range(0, 63) == 0, cur,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 4'h8
                                        : 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
